// File: rtl/dequant_zigzag_block_buffer.sv
// Dequantising zigzag-to-raster ping-pong block buffer feeding the 8x8 IDCT row stream.
// Optional macro DEQ_SATURATE_EN: clamp products to the OUT_W range instead of wrapping.
module dequant_zigzag_block_buffer #(
   parameter int COEF_W = 12,
   parameter int Q_W    = 8,
   parameter int OUT_W  = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic signed [COEF_W-1:0] slave_tdata,
   input  logic                     slave_tvalid,
   input  logic                     slave_tlast,
   output logic                     slave_tready,
   output logic [8*OUT_W-1:0]       master_tdata,
   output logic                     master_tvalid,
   output logic                     master_tlast,
   input  logic                     master_tready,
   input  logic                     q_we,
   input  logic [5:0]               q_addr,
   input  logic [Q_W-1:0]           q_data
);

`ifdef DEQ_SATURATE_EN
   localparam int PROD_W = COEF_W + Q_W + 1;
`else
   // Only the low OUT_W bits survive a wrap, and they equal the low bits of the full product.
   localparam int PROD_W = OUT_W;
`endif

   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic [Q_W-1:0]          q_tab    [64];
   logic [OUT_W-1:0]        bank_mem [2][64];
   logic [1:0][63:0]        bmap;
   logic [1:0]              full;
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [5:0]              fill_idx;
   logic [2:0]              out_row;
   logic                    accept;
   logic                    close_blk;
   logic                    row_hs;
   logic                    release_blk;
   logic [5:0]              wr_nat;
   logic signed [PROD_W-1:0] prod;
   logic [OUT_W-1:0]        deq;

   assign slave_tready  = !reset && !full[wr_ptr];
   assign master_tvalid = !reset && full[rd_ptr];
   assign master_tlast  = master_tvalid && (out_row == 3'd7);

   assign accept      = slave_tvalid && slave_tready;
   assign close_blk   = accept && (slave_tlast || (fill_idx == 6'd63));
   assign row_hs      = master_tvalid && master_tready;
   assign release_blk = row_hs && (out_row == 3'd7);

   assign wr_nat = ZZ[fill_idx];
   assign prod   = PROD_W'(slave_tdata) * PROD_W'(signed'({1'b0, q_tab[wr_nat]}));

`ifdef DEQ_SATURATE_EN
   always_comb begin
      deq = prod[OUT_W-1:0];
      if (prod[PROD_W-1:OUT_W-1] != {(PROD_W-OUT_W+1){prod[PROD_W-1]}})
         deq = prod[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
   end
`else
   assign deq = prod[OUT_W-1:0];
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 64; i++)
            q_tab[i] <= Q_W'(1);
      end else if (q_we) begin
         q_tab[q_addr] <= q_data;
      end
   end

   // Stale bank contents never reach the output because reads are bitmap-masked.
   always_ff @(posedge clock) begin
      if (accept)
         bank_mem[wr_ptr][wr_nat] <= deq;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full     <= '0;
         bmap     <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fill_idx <= '0;
         out_row  <= '0;
      end else begin
         if (release_blk) begin
            full[rd_ptr] <= 1'b0;
            bmap[rd_ptr] <= '0;
            rd_ptr       <= ~rd_ptr;
            out_row      <= '0;
         end else if (row_hs) begin
            out_row <= out_row + 3'd1;
         end
         // Release and close always target different banks, so both apply.
         if (accept) begin
            bmap[wr_ptr][wr_nat] <= 1'b1;
            fill_idx             <= fill_idx + 6'd1;
         end
         if (close_blk) begin
            full[wr_ptr] <= 1'b1;
            wr_ptr       <= ~wr_ptr;
            fill_idx     <= '0;
         end
      end
   end

   always_comb begin
      master_tdata = '0;
      if (master_tvalid) begin
         for (int c = 0; c < 8; c++) begin
            if (bmap[rd_ptr][{out_row, 3'(c)}])
               master_tdata[c*OUT_W +: OUT_W] = bank_mem[rd_ptr][{out_row, 3'(c)}];
         end
      end
   end

endmodule

// File: tb/tb_dequant_zigzag_block_buffer.sv
// Directed bench for dequant_zigzag_block_buffer: vector table for scaling plus ordering,
// EOB, back-pressure, table-write race and mid-operation reset sequences.
module tb_dequant_zigzag_block_buffer;

   localparam int COEF_W = 12;
   localparam int Q_W    = 8;
   localparam int OUT_W  = 16;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic signed [COEF_W-1:0] slave_tdata = '0;
   logic                     slave_tvalid = 1'b0;
   logic                     slave_tlast = 1'b0;
   logic                     slave_tready;
   logic [8*OUT_W-1:0]       master_tdata;
   logic                     master_tvalid;
   logic                     master_tlast;
   logic                     master_tready = 1'b0;
   logic                     q_we = 1'b0;
   logic [5:0]               q_addr = '0;
   logic [Q_W-1:0]           q_data = '0;

   dequant_zigzag_block_buffer #(
      .COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)
   ) dut (
      .clock(clock), .reset(reset),
      .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid),
      .slave_tlast(slave_tlast), .slave_tready(slave_tready),
      .master_tdata(master_tdata), .master_tvalid(master_tvalid),
      .master_tlast(master_tlast), .master_tready(master_tready),
      .q_we(q_we), .q_addr(q_addr), .q_data(q_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      int coef;
      int q;
      int exp_sat;
      int exp_wrap;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;
   int exp_nat [64];
   logic [8*OUT_W-1:0] got_rows [8];
   int zz [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
   vec_t vecs [8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, want);
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      check(name, {127'b0, got}, {127'b0, want});
   endtask

   function automatic logic [127:0] row8(int c0, int c1, int c2, int c3,
                                         int c4, int c5, int c6, int c7);
      return {16'(c7), 16'(c6), 16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   function automatic logic [127:0] model_row(int r);
      logic [127:0] v;
      v = '0;
      for (int c = 0; c < 8; c++) v[c*16 +: 16] = 16'(exp_nat[r*8+c]);
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 64; i++) exp_nat[i] = 0;
   endtask

   task automatic fill_model(input int base, input int n);
      clear_model();
      for (int k = 0; k < n; k++) exp_nat[zz[k]] = base + k;
   endtask

   task automatic write_q(input int a, input int d);
      q_we = 1'b1; q_addr = 6'(a); q_data = 8'(d);
      tick();
      q_we = 1'b0;
   endtask

   task automatic send_beat(input int d, input bit last);
      int waited;
      waited = 0;
      slave_tdata = 12'(d); slave_tvalid = 1'b1; slave_tlast = last;
      while (!slave_tready && waited < 300) begin
         tick();
         waited++;
      end
      if (!slave_tready) begin
         n_total++;
         $display("FAIL send_timeout: slave_tready got 0 expected 1");
      end
      tick();
      slave_tvalid = 1'b0; slave_tlast = 1'b0;
   endtask

   task automatic send_block(input int base, input int n, input bit last_at_end);
      for (int k = 0; k < n; k++) send_beat(base + k, last_at_end && (k == n - 1));
   endtask

   task automatic read_rows(input int n, input bit chk_ready);
      int waited;
      master_tready = 1'b1;
      for (int r = 0; r < n; r++) begin
         waited = 0;
         while (!master_tvalid && waited < 300) begin
            tick();
            waited++;
         end
         if (!master_tvalid) begin
            n_total++;
            $display("FAIL read_timeout: master_tvalid got 0 expected 1 (row %0d)", r);
         end
         got_rows[r] = master_tdata;
         check_bit($sformatf("tlast_row%0d", r), master_tlast, r == 7);
         if (chk_ready && r == 7) check_bit("bp_ready_before_release", slave_tready, 1'b0);
         tick();
         if (chk_ready && r == 7) check_bit("bp_ready_after_release", slave_tready, 1'b1);
      end
      master_tready = 1'b0;
   endtask

   task automatic check_rows(input string tag);
      for (int r = 0; r < 8; r++) check($sformatf("%s_row%0d", tag, r), got_rows[r], model_row(r));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      vecs[0] = '{10, 1, 10, 10};
      vecs[1] = '{-3, 3, -9, -9};
      vecs[2] = '{100, 200, 20000, 20000};
      vecs[3] = '{2047, 255, 32767, -2303};
      vecs[4] = '{-2048, 255, -32768, 2048};
      vecs[5] = '{300, 128, 32767, -27136};
      vecs[6] = '{-1, 255, -255, -255};
      vecs[7] = '{0, 77, 0, 0};

      // reset state
      repeat (3) tick();
      check_bit("rst_tready", slave_tready, 1'b0);
      check_bit("rst_tvalid", master_tvalid, 1'b0);
      check_bit("rst_tlast", master_tlast, 1'b0);
      check("rst_tdata", master_tdata, '0);
      reset = 1'b0;
      tick();
      check_bit("post_rst_tready", slave_tready, 1'b1);
      check_bit("post_rst_tvalid", master_tvalid, 1'b0);

      // identity ordering and latency
      for (int k = 0; k < 63; k++) send_beat(k, 1'b0);
      check_bit("id_valid_early", master_tvalid, 1'b0);
      send_beat(63, 1'b1);
      check_bit("id_latency", master_tvalid, 1'b1);
      read_rows(8, 1'b0);
      check("id_row0_literal", got_rows[0], row8(0, 1, 5, 6, 14, 15, 27, 28));
      check("id_row1_literal", got_rows[1], row8(2, 4, 7, 13, 16, 26, 29, 42));
      fill_model(0, 64);
      check_rows("ident");

      // EOB zero-fill, then next block restarts at index 0
      send_beat(10, 1'b0);
      send_beat(-3, 1'b0);
      send_beat(7, 1'b1);
      read_rows(8, 1'b0);
      check("eob_row0_literal", got_rows[0], row8(10, -3, 0, 0, 0, 0, 0, 0));
      check("eob_row1_literal", got_rows[1], row8(7, 0, 0, 0, 0, 0, 0, 0));
      clear_model(); exp_nat[0] = 10; exp_nat[1] = -3; exp_nat[8] = 7;
      check_rows("eob");
      send_beat(42, 1'b0);
      send_beat(43, 1'b1);
      read_rows(8, 1'b0);
      clear_model(); exp_nat[0] = 42; exp_nat[1] = 43;
      check_rows("eob_next");

      // scaling / saturation vector table
      for (int i = 0; i < 8; i++) begin
         write_q(0, vecs[i].q);
         send_beat(vecs[i].coef, 1'b1);
         read_rows(8, 1'b0);
`ifdef DEQ_SATURATE_EN
         e = vecs[i].exp_sat;
`else
         e = vecs[i].exp_wrap;
`endif
         check($sformatf("vec%0d_row0", i), got_rows[0], row8(e, 0, 0, 0, 0, 0, 0, 0));
         check($sformatf("vec%0d_row7", i), got_rows[7], '0);
      end
      write_q(0, 1);

      // back-pressure: two blocks fill both banks, third waits for release
      send_block(100, 64, 1'b0);
      send_block(200, 64, 1'b0);
      check_bit("bp_stall", slave_tready, 1'b0);
      fill_model(100, 64);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_hold%0d", i), master_tdata, model_row(0));
         check_bit($sformatf("bp_hold_valid%0d", i), master_tvalid, 1'b1);
         tick();
      end
      read_rows(8, 1'b1);
      check_rows("bp_blk1");
      send_block(300, 64, 1'b1);
      read_rows(8, 1'b0);
      fill_model(200, 64);
      check_rows("bp_blk2");
      read_rows(8, 1'b0);
      fill_model(300, 64);
      check_rows("bp_blk3");

      // quant table write racing the coefficient that uses it
      q_we = 1'b1; q_addr = 6'd0; q_data = 8'd4;
      send_beat(5, 1'b1);
      q_we = 1'b0;
      read_rows(8, 1'b0);
      check("race_old_q", got_rows[0], row8(5, 0, 0, 0, 0, 0, 0, 0));
      send_beat(5, 1'b1);
      read_rows(8, 1'b0);
      check("race_new_q", got_rows[0], row8(20, 0, 0, 0, 0, 0, 0, 0));
      write_q(0, 1);

      // reset mid-operation
      write_q(5, 3);
      send_block(0, 64, 1'b1);
      read_rows(3, 1'b0);
      check("mid_row0_q5", got_rows[0], row8(0, 1, 5, 6, 14, 45, 27, 28));
      send_block(1000, 30, 1'b0);
      reset = 1'b1;
      #1;
      check_bit("mrst_tvalid", master_tvalid, 1'b0);
      check_bit("mrst_tready", slave_tready, 1'b0);
      check("mrst_tdata", master_tdata, '0);
      tick();
      tick();
      check_bit("mrst_tvalid_held", master_tvalid, 1'b0);
      check_bit("mrst_tready_held", slave_tready, 1'b0);
      reset = 1'b0;
      tick();
      check_bit("mrst_after_tready", slave_tready, 1'b1);
      check_bit("mrst_after_tvalid", master_tvalid, 1'b0);
      send_block(0, 64, 1'b1);
      read_rows(8, 1'b0);
      fill_model(0, 64);
      check_rows("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
